// File: rtl/io_pkg.sv
// Shared constants for the board-input conditioner: reset levels, default
// timing and pin counts.
package io_pkg;

  localparam logic KEY_RELEASED        = 1'b1;
  localparam logic SW_RESET            = 1'b0;
  localparam int   DEF_DEBOUNCE_CYCLES = 32'd1000000;
  localparam int   DEF_SYNC_STAGES     = 32'd2;
  localparam int   DEF_N_KEYS          = 32'd4;
  localparam int   DEF_N_SW            = 32'd9;

endpackage

// File: rtl/debounce_bit.sv
// One input bit: metastability synchroniser, saturating debounce counter and
// a stable output flop with registered rise/fall pulses.
module debounce_bit import io_pkg::*; #(
  parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int   SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cnt_nxt_s;
  logic                   update_s;
  logic                   clean_r;
  logic                   rise_r;
  logic                   fall_r;

  assign sync_s = sync_r[SYNC_STAGES-1];

  // Synchroniser shift chain, reset to the released/idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], raw};
    end
  end

  // Any return to the stable level restarts the count; it saturates at CNT_MAX.
  always_comb begin
    update_s  = 1'b0;
    cnt_nxt_s = cnt_r;
    if (sync_s == clean_r) begin
      cnt_nxt_s = '0;
    end else if (cnt_r == CNT_MAX) begin
      update_s  = 1'b1;
      cnt_nxt_s = '0;
    end else begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end
  end

  // Counter, stable level and the edge pulses that accompany an update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= '0;
      clean_r <= RESET_VAL;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
    end else begin
      cnt_r   <= cnt_nxt_s;
      clean_r <= update_s ? sync_s : clean_r;
      rise_r  <= update_s & sync_s;
      fall_r  <= update_s & ~sync_s;
    end
  end

  assign clean = clean_r;
  assign rise  = rise_r;
  assign fall  = fall_r;

endmodule

// File: rtl/io_input_conditioner.sv
// Debounced key/switch front end for the memory-mapped I/O read path, with
// key press/release pulses and software-clearable sticky press flags.
module io_input_conditioner import io_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int N_KEYS          = DEF_N_KEYS,
  parameter int N_SW            = DEF_N_SW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_raw,
  input  logic [N_SW-1:0]   sw_raw,
  input  logic [N_KEYS-1:0] sticky_clr,
  output logic [N_KEYS-1:0] key,
  output logic [N_SW-1:0]   sw,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_sticky
);

  logic [N_KEYS-1:0] key_clean_s;
  logic [N_KEYS-1:0] key_rise_s;
  logic [N_KEYS-1:0] key_fall_s;
  logic [N_SW-1:0]   sw_clean_s;
  logic [N_SW-1:0]   sw_rise_s;
  logic [N_SW-1:0]   sw_fall_s;
  logic [N_KEYS-1:0] sticky_r;

  genvar gi;
  generate
    for (gi = 0; gi < N_KEYS; gi++) begin : g_key
      debounce_bit #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES),
        .RESET_VAL       (KEY_RELEASED)
      ) u_db (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (key_raw[gi]),
        .clean (key_clean_s[gi]),
        .rise  (key_rise_s[gi]),
        .fall  (key_fall_s[gi])
      );
    end
    for (gi = 0; gi < N_SW; gi++) begin : g_sw
      debounce_bit #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES),
        .RESET_VAL       (SW_RESET)
      ) u_db (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (sw_raw[gi]),
        .clean (sw_clean_s[gi]),
        .rise  (sw_rise_s[gi]),
        .fall  (sw_fall_s[gi])
      );
    end
  endgenerate

  // Sticky flags: a press in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_r <= '0;
    end else begin
      sticky_r <= (sticky_r & ~sticky_clr) | key_fall_s;
    end
  end

  // Switch edges are not exported; keys are active-low, so a press is a fall.
  assign key         = key_clean_s;
  assign sw          = sw_clean_s;
  assign key_press   = key_fall_s;
  assign key_release = key_rise_s;
  assign key_sticky  = sticky_r;

endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed scoreboard bench for io_input_conditioner with a short debounce.
module tb_io_input_conditioner;

  localparam int DB = 8;
  localparam int SS = 2;
  localparam int LAT = DB + SS;

  localparam int S_KEY = 0;
  localparam int S_SW  = 1;
  localparam int S_PR  = 2;
  localparam int S_RL  = 3;
  localparam int S_ST  = 4;

  typedef struct {
    int         due;
    int         sel;
    logic [8:0] exp;
    string      tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key_raw;
  logic [8:0] sw_raw;
  logic [3:0] sticky_clr;
  logic [3:0] key;
  logic [8:0] sw;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic [3:0] key_sticky;

  exp_t q[$];
  int   cyc     = 0;
  int   n_total = 0;
  int   n_pass  = 0;
  int   t0;

  io_input_conditioner #(
    .DEBOUNCE_CYCLES (DB),
    .SYNC_STAGES     (SS),
    .N_KEYS          (4),
    .N_SW            (9)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_raw     (key_raw),
    .sw_raw      (sw_raw),
    .sticky_clr  (sticky_clr),
    .key         (key),
    .sw          (sw),
    .key_press   (key_press),
    .key_release (key_release),
    .key_sticky  (key_sticky)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] obs(int sel);
    case (sel)
      S_KEY:   return {5'b0, key};
      S_SW:    return sw;
      S_PR:    return {5'b0, key_press};
      S_RL:    return {5'b0, key_release};
      S_ST:    return {5'b0, key_sticky};
      default: return 9'h1ff;
    endcase
  endfunction

  task automatic push(int dly, int sel, logic [8:0] val, string tag);
    exp_t e;
    e.due = cyc + dly;
    e.sel = sel;
    e.exp = val;
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic check_due();
    logic [8:0] o;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].due <= cyc) begin
        o = obs(q[i].sel);
        n_total++;
        assert (q[i].due == cyc && o === q[i].exp) n_pass++;
        else $error("FAIL %s cyc=%0d due=%0d observed=%h expected=%h",
                    q[i].tag, cyc, q[i].due, o, q[i].exp);
        q.delete(i);
      end
    end
  endtask

  task automatic tick(int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      check_due();
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    key_raw    = 4'h0;
    sw_raw     = 9'h1ff;
    sticky_clr = 4'h0;

    // Reset holds outputs at idle levels regardless of the pins.
    for (int d = 1; d <= 5; d++) begin
      push(d, S_KEY, 9'h00f, "rst_key");
      push(d, S_SW,  9'h000, "rst_sw");
      push(d, S_PR,  9'h000, "rst_press");
      push(d, S_RL,  9'h000, "rst_release");
      push(d, S_ST,  9'h000, "rst_sticky");
    end
    tick(5);
    key_raw = 4'hf;
    sw_raw  = 9'h000;
    tick(2);
    rst_n = 1'b1;
    tick(3);

    // Clean press on key 0.
    key_raw = 4'b1110;
    for (int d = 1; d < LAT; d++) begin
      push(d, S_KEY, 9'h00f, "press_hold");
      push(d, S_PR,  9'h000, "press_early");
    end
    push(LAT,     S_KEY, 9'h00e, "press_key");
    push(LAT,     S_PR,  9'h001, "press_pulse");
    push(LAT,     S_RL,  9'h000, "press_norel");
    push(LAT,     S_ST,  9'h000, "press_st_pre");
    push(LAT + 1, S_PR,  9'h000, "press_pulse_end");
    push(LAT + 1, S_ST,  9'h001, "press_sticky");
    tick(LAT + 2);

    // Five-cycle glitch on key 1 must not propagate.
    for (int d = 1; d <= 20; d++) begin
      push(d, S_KEY, 9'h00e, "glitch_key");
      push(d, S_PR,  9'h000, "glitch_press");
      push(d, S_RL,  9'h000, "glitch_rel");
      push(d, S_ST,  9'h001, "glitch_sticky");
    end
    key_raw = 4'b1100;
    tick(5);
    key_raw = 4'b1110;
    tick(15);

    // Bouncing switch 3, settling high.
    for (int d = 1; d <= 12; d++) push(d, S_SW, 9'h000, "bounce_quiet");
    for (int b = 0; b < 4; b++) begin
      sw_raw = (b % 2 == 0) ? 9'h008 : 9'h000;
      tick(3);
    end
    sw_raw = 9'h008;
    for (int d = 1; d < LAT; d++) push(d, S_SW, 9'h000, "bounce_settle");
    push(LAT,     S_SW, 9'h008, "bounce_rise");
    push(LAT + 1, S_SW, 9'h008, "bounce_hold");
    tick(LAT + 2);

    // Press key 2 to set its sticky flag.
    key_raw = 4'b1010;
    push(LAT,     S_PR, 9'h004, "k2_press");
    push(LAT + 1, S_ST, 9'h005, "k2_sticky");
    tick(LAT + 1);
    sticky_clr = 4'b0100;
    push(1, S_ST, 9'h001, "clr_k2");
    tick(1);
    sticky_clr = 4'b0000;
    sticky_clr = 4'b0001 & 4'b0000;
    push(1, S_ST, 9'h001, "clr_stays");
    tick(1);

    // Release key 2, then re-press with the clear landing on the press pulse.
    key_raw = 4'b1110;
    push(LAT, S_RL,  9'h004, "k2_release");
    push(LAT, S_KEY, 9'h00e, "k2_released");
    tick(LAT + 2);
    key_raw = 4'b1010;
    push(LAT,     S_PR, 9'h004, "race_press");
    push(LAT,     S_ST, 9'h001, "race_st_pre");
    push(LAT + 1, S_ST, 9'h005, "race_set_wins");
    push(LAT + 2, S_ST, 9'h005, "race_hold");
    tick(LAT);
    sticky_clr = 4'b0100;
    tick(1);
    sticky_clr = 4'b0000;
    tick(1);

    // Reset in the middle of a key 3 debounce.
    key_raw = 4'b0010;
    tick(5);
    rst_n = 1'b0;
    push(1, S_KEY, 9'h00f, "midrst_key");
    push(1, S_ST,  9'h000, "midrst_sticky");
    push(1, S_SW,  9'h000, "midrst_sw");
    tick(3);
    rst_n = 1'b1;
    t0 = cyc;
    for (int d = 1; d < LAT; d++) begin
      push(d, S_KEY, 9'h00f, "rerun_hold");
      push(d, S_PR,  9'h000, "rerun_nopress");
      push(d, S_SW,  9'h000, "rerun_sw_hold");
    end
    push(LAT,     S_KEY, 9'h002, "rerun_key");
    push(LAT,     S_PR,  9'h00d, "rerun_press");
    push(LAT,     S_SW,  9'h008, "rerun_sw");
    push(LAT + 1, S_PR,  9'h000, "rerun_press_end");
    push(LAT + 1, S_ST,  9'h00d, "rerun_sticky");
    tick(LAT + 3);

    n_total++;
    assert (q.size() == 0 && cyc > t0) n_pass++;
    else $error("FAIL scoreboard_drain observed=%0d expected=0 pending", q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/io_input_conditioner.md
Name: io_input_conditioner

Overview:
Board-input front end that sits directly upstream of the data memory's memory-mapped I/O read path. It synchronises the raw KEY[3:0] and SW[8:0] pins and debounces every bit. It delivers clean levels on the same `key`/`sw` nets the memory-mapped I/O port samples. It also produces one-cycle key-press pulses and sticky press flags, so software polling does not miss short presses.

Parameters:
- DEBOUNCE_CYCLES, 1000000, number of consecutive clk cycles a synchronised input must hold a new value before the clean output follows (20 ms at 50 MHz); legal range 2..2^24-1.
- SYNC_STAGES, 2, flip-flop depth of the metastability synchroniser per bit; legal range 2..4.
- N_KEYS, 4, number of push-button inputs.
- N_SW, 9, number of slide-switch inputs.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- key_raw  input  N_KEYS  board push-buttons, active-low (0 = pressed), asynchronous to clk.
- sw_raw  input  N_SW  board slide switches, asynchronous to clk.
- sticky_clr  input  N_KEYS  one-cycle clear strobe per sticky flag (driven by the I/O write decode).
- key  output  N_KEYS  debounced buttons, still active-low, feeds the memory I/O key input.
- sw  output  N_SW  debounced switches, feeds the memory I/O sw input.
- key_press  output  N_KEYS  one-cycle pulse on a debounced 1->0 (press) transition.
- key_release  output  N_KEYS  one-cycle pulse on a debounced 0->1 (release) transition.
- key_sticky  output  N_KEYS  set by key_press, held until cleared.

Behaviour:
- Reset (asynchronous, while rst_n=0):
  - synchroniser flops for keys = 1 and for switches = 0;
  - key = all ones (released) and sw = 0;
  - key_press, key_release and key_sticky = 0;
  - all debounce counters = 0.
- Per-bit pipeline: SYNC_STAGES flops, then a debounce counter (width clog2(DEBOUNCE_CYCLES)), then the stable output flop.
- Counter rules, evaluated each cycle:
  - synchronised value == stable output: counter <= 0.
  - synchronised value != stable output and counter == DEBOUNCE_CYCLES-1: stable output <= synchronised value, counter <= 0.
  - otherwise: counter <= counter+1.
- Latency: a raw change held steady appears on the clean output exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges after the first edge that samples it.
- Glitch rejection: any return to the old value before the count completes resets the counter. A pulse shorter than DEBOUNCE_CYCLES synchronised cycles never reaches the output.
- Counter limits: the counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- key_press[i] is asserted in the same cycle key[i] registers 1->0 and deasserted the next cycle. key_release[i] behaves the same way for 0->1. They are registered outputs with no combinational path from inputs.
- key_sticky[i]:
  - set on key_press[i]; cleared when sticky_clr[i]=1;
  - if set and clear coincide in the same cycle, set wins and the flag stays 1;
  - sticky_clr on an already-clear flag has no effect.
- Bits are fully independent; simultaneous transitions on several bits each complete on their own schedule.
- Reset mid-debounce: the in-progress count is discarded; after release of rst_n the outputs restart from their reset values and any held input re-debounces from zero.
- Reset deassertion is not synchronised here; the top level supplies a synchronously deasserted rst_n.

Decomposition:
- Shared package io_pkg holds:
  - KEY_RELEASED constant (1'b1) and SW_RESET constant (1'b0);
  - default DEBOUNCE_CYCLES and SYNC_STAGES;
  - N_KEYS and N_SW.
- One sub-module, debounce_bit, with parameters DEBOUNCE_CYCLES, SYNC_STAGES and RESET_VAL. Its ports are clk, rst_n, raw, clean, rise and fall.
- io_input_conditioner instantiates N_KEYS+N_SW copies via generate and adds the sticky-flag logic.

Test Plan (DEBOUNCE_CYCLES=8, SYNC_STAGES=2):
- Reset: hold rst_n=0 with key_raw=4'h0 and sw_raw=9'h1FF -> key=4'hF, sw=0, key_press=key_release=key_sticky=0 throughout.
- Clean press: after reset, drive key_raw[0] 1->0 and hold -> key[0] falls exactly 10 edges later. key_press[0]=1 for exactly one cycle at that edge, then key_sticky[0]=1.
- Glitch: drop key_raw[1] to 0 for 5 cycles, then return to 1 -> key[1] stays 1; key_press, key_release and key_sticky stay 0.
- Bounce: toggle sw_raw[3] every 3 cycles 4 times, then hold 1 -> sw[3] rises 10 edges after the final transition, with no earlier change.
- Sticky clear race: with key_sticky[2]=1, pulse sticky_clr[2] -> flag clears. Then force a new key_press[2] in the same cycle as sticky_clr[2] -> flag remains 1.
- Reset mid-count: start a key_raw[3] press, assert rst_n=0 after 5 cycles, release it and keep key_raw[3]=0 -> key[3] falls 10 edges after rst_n rises, with one key_press[3] pulse.
